// File: rtl/uart_pkg.sv
// Shared register offsets, response codes and FSM state types for the UART AXI-lite slave.
package uart_pkg;

   localparam logic [11:0] OFF_TXDATA  = 12'h000;
   localparam logic [11:0] OFF_STATUS  = 12'h004;
   localparam logic [11:0] OFF_DIVISOR = 12'h008;

   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERR  = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;
   typedef enum logic {R_IDLE, R_RESP} rd_state_t;
   typedef enum logic {W_IDLE, W_RESP} wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and wrap-bit pointers.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count = wptr - rptr;

endmodule

// File: rtl/uart_axil_slave.sv
// AXI-lite register front end for an 8N1 UART transmitter with a TX byte FIFO.
module uart_axil_slave
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic        rresp,
   output logic        rvalid,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [31:0] wstrb,
   input  logic        wvalid,
   output logic        wready,
   input  logic        bready,
   output logic        bresp,
   output logic        bvalid,
   output logic        tx
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   rd_state_t  r_state, r_next;
   wr_state_t  w_state, w_next;
   ser_state_t s_state, s_next;

   logic          ar_fire, w_fire;
   logic [31:0]   rd_data_d;
   logic          rd_resp_d, wr_resp_d;
   logic [15:0]   divisor;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          ser_busy, bit_end;
   logic [15:0]   ser_cnt, div_lat;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          unused_bits;

   assign unused_bits = ^{araddr[31:12], awaddr[31:12], wstrb[31:4], wdata[31:16]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ---------------- read channel ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= R_IDLE;
      else      r_state <= r_next;
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      ar_fire = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               ar_fire = 1'b1;
               r_next  = R_RESP;
            end
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Decode uses current register state, so a same-cycle push is not yet visible.
   always_comb begin
      rd_data_d = '0;
      rd_resp_d = RESP_OKAY;
      case (araddr[11:0])
         OFF_TXDATA:  rd_data_d = '0;
         OFF_STATUS:  rd_data_d = {16'h0, 8'(fifo_count), 5'h0, ser_busy, fifo_empty, fifo_full};
         OFF_DIVISOR: rd_data_d = {16'h0, divisor};
         default:     rd_resp_d = RESP_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
         rresp <= RESP_OKAY;
      end else if (ar_fire) begin
         rdata <= rd_data_d;
         rresp <= rd_resp_d;
      end
   end

   // ---------------- write channel ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) w_state <= W_IDLE;
      else      w_state <= w_next;
   end

   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      w_fire  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = 1'b1;
            wready  = 1'b1;
            if (awvalid && wvalid) begin
               w_fire = 1'b1;
               w_next = W_RESP;
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      wr_resp_d = RESP_OKAY;
      case (awaddr[11:0])
         OFF_TXDATA:  if (wstrb[0] && fifo_full) wr_resp_d = RESP_ERR;
         OFF_STATUS:  wr_resp_d = RESP_OKAY;
         OFF_DIVISOR: wr_resp_d = RESP_OKAY;
         default:     wr_resp_d = RESP_ERR;
      endcase
   end

   assign fifo_push = w_fire && (awaddr[11:0] == OFF_TXDATA) && wstrb[0] && !fifo_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bresp   <= RESP_OKAY;
         divisor <= DIV_RESET;
      end else if (w_fire) begin
         bresp <= wr_resp_d;
         if (awaddr[11:0] == OFF_DIVISOR) begin
            if (wstrb[0]) divisor[7:0]  <= wdata[7:0];
            if (wstrb[1]) divisor[15:8] <= wdata[15:8];
         end
      end
   end

   // ---------------- serializer ----------------
   assign ser_busy = (s_state != S_IDLE);
   assign bit_end  = (ser_cnt == div_lat - 16'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) s_state <= S_IDLE;
      else      s_state <= s_next;
   end

   // The stop bit's last cycle pops directly into S_START so back-to-back frames have no idle gap.
   always_comb begin
      s_next   = s_state;
      fifo_pop = 1'b0;
      tx       = 1'b1;
      case (s_state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               s_next   = S_START;
            end
         end
         S_START: begin
            tx = 1'b0;
            if (bit_end) s_next = S_DATA;
         end
         S_DATA: begin
            tx = shift[0];
            if (bit_end && bit_idx == 3'd7) s_next = S_STOP;
         end
         S_STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  s_next   = S_START;
               end else begin
                  s_next = S_IDLE;
               end
            end
         end
         default: s_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ser_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         div_lat <= 16'd1;
      end else if (fifo_pop) begin
         shift   <= fifo_dout;
         div_lat <= (divisor == 16'd0) ? 16'd1 : divisor;
         ser_cnt <= '0;
         bit_idx <= '0;
      end else if (s_state != S_IDLE) begin
         if (bit_end) begin
            ser_cnt <= '0;
            if (s_state == S_DATA) begin
               shift   <= shift >> 1;
               bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            ser_cnt <= ser_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_axil_slave.sv
// Directed bench for uart_axil_slave: register table, 8N1 framing, FIFO full, backpressure, reset.
module tb_uart_axil_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic        rready = 1'b1;
   logic [31:0] rdata;
   logic        rresp;
   logic        rvalid;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [31:0] wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic        bready = 1'b1;
   logic        bresp;
   logic        bvalid;
   logic        tx;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   uart_axil_slave #(.FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bready(bready), .bresp(bresp), .bvalid(bvalid),
      .tx(tx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input bit hold,
                           output logic [31:0] data, output logic resp);
      int unsigned n;
      @(negedge clk);
      araddr  = addr;
      arvalid = 1'b1;
      rready  = !hold;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      if (!arready) check("ar_timeout", 32'(arready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_latency", 32'(rvalid), 32'd1);
      data = rdata;
      resp = rresp;
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("r_hold", {rvalid, arready, rresp, rdata[28:0]}, {1'b1, 1'b0, resp, data[28:0]});
         end
         rready = 1'b1;
      end
      @(posedge clk);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit hold, output logic resp);
      int unsigned n;
      @(negedge clk);
      awaddr  = addr;
      wdata   = data;
      wstrb   = {28'h0, strb};
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = !hold;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
      if (!(awready && wready)) check("aw_timeout", 32'(awready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("bvalid_latency", 32'(bvalid), 32'd1);
      resp = bresp;
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_hold", {bvalid, awready, wready, bresp}, {1'b1, 1'b0, 1'b0, resp});
         end
         bready = 1'b1;
      end
      @(posedge clk);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        tbl[14];
   logic [31:0] d;
   logic        r;

   initial begin
      tbl[0]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'h0000_0010};
      tbl[1]  = '{1'b1, 32'h0000_0008, 32'h0000_1234, 4'h3, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'h0000_1234};
      tbl[3]  = '{1'b1, 32'h0000_0008, 32'h0000_0056, 4'h1, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'h0000_1256};
      tbl[5]  = '{1'b1, 32'h0000_0008, 32'h0000_7800, 4'h2, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 32'h1000_0008, 32'h0,         4'h0, 1'b0, 32'h0000_7856};
      tbl[7]  = '{1'b1, 32'h0000_0008, 32'hFFFF_0004, 4'hF, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'h0000_0004};
      tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h0};
      tbl[11] = '{1'b1, 32'h0000_000C, 32'h0000_0099, 4'hF, 1'b1, 32'h0};
      tbl[12] = '{1'b1, 32'h0000_0000, 32'h0000_0055, 4'h0, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 1'b0, 32'h0000_0002};

      // reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {24'h0, arready, awready, wready, rvalid, bvalid, rresp, bresp, tx},
            32'b1110_0001);
      check("reset_rdata", rdata, 32'h0);
      rst = 1'b1;

      // register table (test 1 and 4 cases included)
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0, r);
            check($sformatf("vec%0d_bresp", i), 32'(r), 32'(tbl[i].exp_resp));
         end else begin
            axi_read(tbl[i].addr, 1'b0, d, r);
            check($sformatf("vec%0d_rresp", i), 32'(r), 32'(tbl[i].exp_resp));
            check($sformatf("vec%0d_rdata", i), d, tbl[i].exp_rdata);
         end
      end
      axi_read(32'h0000_0008, 1'b0, d, r);
      check("div_after_bad_write", d, 32'h0000_0004);
      check("tx_idle", 32'(tx), 32'd1);

      // one 0xA5 frame at divisor 4, STATUS sampled mid-frame
      axi_write(32'h0000_0008, 32'h0000_0004, 4'h3, 1'b0, r);
      fork
         begin
            axi_write(32'h0000_0000, 32'h0000_00A5, 4'h1, 1'b0, r);
            check("txa5_bresp", 32'(r), 32'd0);
            repeat (6) @(negedge clk);
            axi_read(32'h0000_0004, 1'b0, d, r);
            check("status_busy", d, 32'h0000_0006);
         end
         begin
            int unsigned n;
            logic [7:0]  byte_v;
            logic        exp_bit;
            bit          ok;
            byte_v = 8'hA5;
            n = 0;
            @(negedge clk);
            while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
            check("start_seen", 32'(tx), 32'd0);
            for (int k = 0; k < 10; k++) begin
               exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : byte_v[k-1];
               ok = 1'b1;
               for (int c = 0; c < 4; c++) begin
                  if (k != 0 || c != 0) @(negedge clk);
                  if (tx !== exp_bit) ok = 1'b0;
               end
               check($sformatf("frame_bit%0d", k), 32'(ok), 32'd1);
            end
         end
      join
      repeat (2) @(negedge clk);
      axi_read(32'h0000_0004, 1'b0, d, r);
      check("status_done", d, 32'h0000_0002);

      // FIFO fill at divisor 64: first byte leaves to the serializer immediately
      axi_write(32'h0000_0008, 32'h0000_0040, 4'h3, 1'b0, r);
      for (int i = 0; i < 8; i++) begin
         axi_write(32'h0000_0000, 32'h0000_0000, 4'h1, 1'b0, r);
         check($sformatf("fill%0d_bresp", i), 32'(r), 32'd0);
      end
      axi_read(32'h0000_0004, 1'b0, d, r);
      check("status_7", d, 32'h0000_0704);
      axi_write(32'h0000_0000, 32'h0000_0000, 4'h1, 1'b0, r);
      check("ninth_bresp", 32'(r), 32'd0);
      axi_read(32'h0000_0004, 1'b0, d, r);
      check("status_full", d, 32'h0000_0805);
      axi_write(32'h0000_0000, 32'h0000_0000, 4'h1, 1'b0, r);
      check("overflow_bresp", 32'(r), 32'd1);

      // backpressure on both response channels
      axi_read(32'h0000_0004, 1'b1, d, r);
      check("held_rdata", d, 32'h0000_0805);
      axi_write(32'h0000_0008, 32'h0000_0040, 4'h3, 1'b1, r);
      check("held_bresp", 32'(r), 32'd0);

      // reset in the middle of a frame
      begin
         int unsigned n;
         n = 0;
         @(negedge clk);
         while (tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
         check("midframe_low", 32'(tx), 32'd0);
         rst = 1'b0;
         #1;
         check("reset_tx_async", 32'(tx), 32'd1);
         @(negedge clk);
         rst = 1'b1;
      end
      axi_read(32'h0000_0004, 1'b0, d, r);
      check("status_after_rst", d, 32'h0000_0002);
      axi_read(32'h0000_0008, 1'b0, d, r);
      check("div_after_rst", d, 32'h0000_0010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
